// File: rtl/expmul_row_sched.sv
// expmul_row_sched: per-row initiator/accumulator for the expmul unit.
// Takes one query row's (score, shifted value) stream, tracks the running max,
// issues one expmul request per element carrying the current accumulator, folds
// each response back with a saturating add and emits the row result.
// Optional build macro EXPMUL_SCHED_SAT_FLAG_EN adds sat_out, a sticky per-row
// flag that is set when any accumulation in the row clamped.
module expmul_row_sched #(
   parameter int unsigned SCORE_W  = 16,
   parameter int unsigned VSHIFT_W = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   // upstream element stream
   input  logic                vld_in,
   output logic                rdy_out,
   input  logic [SCORE_W-1:0]  s_in,
   input  logic [VSHIFT_W-1:0] v_star_in,
   input  logic                last_in,
   // expmul request
   output logic                em_vld_out,
   input  logic                em_rdy_in,
   output logic [SCORE_W-1:0]  em_m_out,
   output logic [SCORE_W-1:0]  em_m_prev_out,
   output logic [VSHIFT_W-1:0] em_o_star_prev_out,
   output logic [SCORE_W-1:0]  em_s_out,
   output logic [VSHIFT_W-1:0] em_v_star_out,
   // expmul response
   input  logic                em_vld_in,
   output logic                em_rdy_out,
   input  logic [VSHIFT_W-1:0] em_exp_v_in,
   input  logic [VSHIFT_W-1:0] em_exp_o_in,
   // downstream row result
`ifdef EXPMUL_SCHED_SAT_FLAG_EN
   output logic                sat_out,
`endif
   output logic                vld_out,
   input  logic                rdy_in,
   output logic [VSHIFT_W-1:0] o_star_out,
   output logic [SCORE_W-1:0]  m_out,
   output logic [CNT_W-1:0]    row_len_out
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StResp = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [SCORE_W-1:0]  s_q, s_d;
   logic [SCORE_W-1:0]  m_req_q, m_req_d;
   logic [SCORE_W-1:0]  m_prev_req_q, m_prev_req_d;
   logic [SCORE_W-1:0]  m_q, m_d;
   logic [VSHIFT_W-1:0] v_q, v_d;
   logic [VSHIFT_W-1:0] o_prev_q, o_prev_d;
   logic [VSHIFT_W-1:0] o_star_q, o_star_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_q, last_d;
   logic                first_q, first_d;
`ifdef EXPMUL_SCHED_SAT_FLAG_EN
   logic                sat_q, sat_d;
`endif

   logic [SCORE_W-1:0]  m_prev_sel, m_req_sel;
   logic [VSHIFT_W:0]   sum_w;
   logic                sat_hi, sat_lo;
   logic [VSHIFT_W-1:0] sum_sat;

   // First element of a row uses its own score as the previous max, so
   // exp(m_prev - m) = 1 and the (zero) accumulator contributes nothing.
   assign m_prev_sel = first_q ? s_in : m_q;
   // Strict compare: ties keep the previous max.
   assign m_req_sel  = ($signed(s_in) > $signed(m_prev_sel)) ? s_in : m_prev_sel;

   // One extra bit of headroom; overflow shows as the top two bits disagreeing.
   assign sum_w   = {em_exp_o_in[VSHIFT_W-1], em_exp_o_in} + {em_exp_v_in[VSHIFT_W-1], em_exp_v_in};
   assign sat_hi  = ~sum_w[VSHIFT_W] & sum_w[VSHIFT_W-1];
   assign sat_lo  = sum_w[VSHIFT_W] & ~sum_w[VSHIFT_W-1];
   assign sum_sat = sat_hi ? {1'b0, {(VSHIFT_W-1){1'b1}}} :
                    sat_lo ? {1'b1, {(VSHIFT_W-1){1'b0}}} : sum_w[VSHIFT_W-1:0];

   // Next-state: FSM plus the row registers it loads in each state.
   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      v_d          = v_q;
      last_d       = last_q;
      m_req_d      = m_req_q;
      m_prev_req_d = m_prev_req_q;
      o_prev_d     = o_prev_q;
      o_star_d     = o_star_q;
      m_d          = m_q;
      cnt_d        = cnt_q;
      first_d      = first_q;
`ifdef EXPMUL_SCHED_SAT_FLAG_EN
      sat_d        = sat_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (vld_in) begin
               s_d          = s_in;
               v_d          = v_star_in;
               last_d       = last_in;
               m_prev_req_d = m_prev_sel;
               m_req_d      = m_req_sel;
               o_prev_d     = first_q ? '0 : o_star_q;
               state_d      = StReq;
            end
         end
         StReq: begin
            if (em_rdy_in) state_d = StResp;
         end
         StResp: begin
            if (em_vld_in) begin
               o_star_d = sum_sat;
               m_d      = m_req_q;
               first_d  = 1'b0;
               cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef EXPMUL_SCHED_SAT_FLAG_EN
               sat_d    = sat_q | sat_hi | sat_lo;
`endif
               state_d  = last_q ? StDone : StIdle;
            end
         end
         StDone: begin
            if (rdy_in) begin
               o_star_d = '0;
               m_d      = '0;
               cnt_d    = '0;
               first_d  = 1'b1;
`ifdef EXPMUL_SCHED_SAT_FLAG_EN
               sat_d    = 1'b0;
`endif
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         s_q          <= '0;
         v_q          <= '0;
         last_q       <= 1'b0;
         m_req_q      <= '0;
         m_prev_req_q <= '0;
         o_prev_q     <= '0;
         o_star_q     <= '0;
         m_q          <= '0;
         cnt_q        <= '0;
         first_q      <= 1'b1;
`ifdef EXPMUL_SCHED_SAT_FLAG_EN
         sat_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         v_q          <= v_d;
         last_q       <= last_d;
         m_req_q      <= m_req_d;
         m_prev_req_q <= m_prev_req_d;
         o_prev_q     <= o_prev_d;
         o_star_q     <= o_star_d;
         m_q          <= m_d;
         cnt_q        <= cnt_d;
         first_q      <= first_d;
`ifdef EXPMUL_SCHED_SAT_FLAG_EN
         sat_q        <= sat_d;
`endif
      end
   end

   // Handshakes decode from state only; gated by rst so they drop at once.
   assign rdy_out    = rst & (state_q == StIdle);
   assign em_vld_out = rst & (state_q == StReq);
   assign em_rdy_out = rst & (state_q == StResp);
   assign vld_out    = rst & (state_q == StDone);

   assign em_m_out           = m_req_q;
   assign em_m_prev_out      = m_prev_req_q;
   assign em_o_star_prev_out = o_prev_q;
   assign em_s_out           = s_q;
   assign em_v_star_out      = v_q;

   assign o_star_out  = o_star_q;
   assign m_out       = m_q;
   assign row_len_out = cnt_q;
`ifdef EXPMUL_SCHED_SAT_FLAG_EN
   assign sat_out     = sat_q;
`endif

endmodule
